tlk2711_axil_reg_bridge: RTL and testbench

//  AXI4-Lite slave that converts PS register accesses into the single-cycle wen/ren register port of tlk2711_top.

---
 rtl/tlk2711_axil_reg_bridge.sv | 223 ++++++++++++++++++++++
 tb/tb_tlk2711_axil_reg_bridge.sv | 393 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tlk2711_axil_reg_bridge.sv
// AXI4-Lite slave bridging PS register accesses onto the single-cycle wen/ren register port.
// Write and read channels are independent FSMs, each with one transaction in flight.
module tlk2711_axil_reg_bridge #(
    parameter int unsigned AXIL_ADDR_WIDTH = 32,
    parameter int unsigned RD_LATENCY      = 1
) (
    input  logic                       ps_clk,
    input  logic                       ps_rst,
    input  logic [AXIL_ADDR_WIDTH-1:0] s_axil_awaddr,
    input  logic                       s_axil_awvalid,
    output logic                       s_axil_awready,
    input  logic [63:0]                s_axil_wdata,
    input  logic [7:0]                 s_axil_wstrb,
    input  logic                       s_axil_wvalid,
    output logic                       s_axil_wready,
    output logic [1:0]                 s_axil_bresp,
    output logic                       s_axil_bvalid,
    input  logic                       s_axil_bready,
    input  logic [AXIL_ADDR_WIDTH-1:0] s_axil_araddr,
    input  logic                       s_axil_arvalid,
    output logic                       s_axil_arready,
    output logic [63:0]                s_axil_rdata,
    output logic [1:0]                 s_axil_rresp,
    output logic                       s_axil_rvalid,
    input  logic                       s_axil_rready,
    output logic                       o_reg_wen,
    output logic [15:0]                o_reg_waddr,
    output logic [63:0]                o_reg_wdata,
    output logic                       o_reg_ren,
    output logic [15:0]                o_reg_raddr,
    input  logic [63:0]                i_reg_rdata
);

    localparam logic [1:0] RespOkay   = 2'b00;
    localparam logic [1:0] RespSlverr = 2'b10;
    localparam logic [1:0] RespDecerr = 2'b11;

    typedef enum logic [1:0] {StWIdle, StWIssue, StWResp} w_state_e;
    typedef enum logic [1:0] {StRIdle, StRIssue, StRWait, StRResp} r_state_e;

    // ---------------- write channel ----------------
    w_state_e                   w_state_q, w_state_d;
    logic                       aw_got_q, aw_got_d;
    logic                       w_got_q, w_got_d;
    logic                       awready_q, awready_d;
    logic                       wready_q, wready_d;
    logic [AXIL_ADDR_WIDTH-1:0] awaddr_q, awaddr_d;
    logic [63:0]                wdata_q, wdata_d;
    logic [7:0]                 wstrb_q, wstrb_d;
    logic [1:0]                 bresp_q, bresp_d;
    logic [1:0]                 w_class;
    logic                       aw_hs, w_hs;

    assign aw_hs = s_axil_awvalid & awready_q;
    assign w_hs  = s_axil_wvalid & wready_q;

    // DECERR outranks SLVERR
    always_comb begin
        if (awaddr_q[AXIL_ADDR_WIDTH-1:16] != '0) begin
            w_class = RespDecerr;
        end else if (awaddr_q[2:0] != 3'b000 || wstrb_q != 8'hFF) begin
            w_class = RespSlverr;
        end else begin
            w_class = RespOkay;
        end
    end

    always_ff @(posedge ps_clk or posedge ps_rst) begin
        if (ps_rst) begin
            w_state_q <= StWIdle;
            aw_got_q  <= 1'b0;
            w_got_q   <= 1'b0;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            awaddr_q  <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            bresp_q   <= RespOkay;
        end else begin
            w_state_q <= w_state_d;
            aw_got_q  <= aw_got_d;
            w_got_q   <= w_got_d;
            awready_q <= awready_d;
            wready_q  <= wready_d;
            awaddr_q  <= awaddr_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            bresp_q   <= bresp_d;
        end
    end

    always_comb begin
        w_state_d = w_state_q;
        unique case (w_state_q)
            StWIdle:  if (aw_got_d && w_got_d) w_state_d = StWIssue;
            StWIssue: w_state_d = StWResp;
            StWResp:  if (s_axil_bready) w_state_d = StWIdle;
            default:  w_state_d = StWIdle;
        endcase
    end

    always_comb begin
        aw_got_d = aw_got_q;
        w_got_d  = w_got_q;
        awaddr_d = awaddr_q;
        wdata_d  = wdata_q;
        wstrb_d  = wstrb_q;
        bresp_d  = bresp_q;
        if (aw_hs) begin
            aw_got_d = 1'b1;
            awaddr_d = s_axil_awaddr;
        end
        if (w_hs) begin
            w_got_d = 1'b1;
            wdata_d = s_axil_wdata;
            wstrb_d = s_axil_wstrb;
        end
        if (w_state_q == StWIssue) begin
            bresp_d  = w_class;
            aw_got_d = 1'b0;
            w_got_d  = 1'b0;
        end
        awready_d = (w_state_d == StWIdle) && !aw_got_d;
        wready_d  = (w_state_d == StWIdle) && !w_got_d;
    end

    always_comb begin
        o_reg_wen      = (w_state_q == StWIssue) && (w_class == RespOkay);
        o_reg_waddr    = awaddr_q[15:0];
        o_reg_wdata    = wdata_q;
        s_axil_awready = awready_q;
        s_axil_wready  = wready_q;
        s_axil_bvalid  = (w_state_q == StWResp);
        s_axil_bresp   = bresp_q;
    end

    // ---------------- read channel ----------------
    r_state_e                   r_state_q, r_state_d;
    logic                       arready_q, arready_d;
    logic [AXIL_ADDR_WIDTH-1:0] araddr_q, araddr_d;
    logic [63:0]                rdata_q, rdata_d;
    logic [1:0]                 rresp_q, rresp_d;
    logic [1:0]                 cnt_q, cnt_d;
    logic [1:0]                 r_class;
    logic                       ar_hs;

    assign ar_hs = s_axil_arvalid & arready_q;

    always_comb begin
        if (araddr_q[AXIL_ADDR_WIDTH-1:16] != '0) begin
            r_class = RespDecerr;
        end else if (araddr_q[2:0] != 3'b000) begin
            r_class = RespSlverr;
        end else begin
            r_class = RespOkay;
        end
    end

    always_ff @(posedge ps_clk or posedge ps_rst) begin
        if (ps_rst) begin
            r_state_q <= StRIdle;
            arready_q <= 1'b0;
            araddr_q  <= '0;
            rdata_q   <= '0;
            rresp_q   <= RespOkay;
            cnt_q     <= '0;
        end else begin
            r_state_q <= r_state_d;
            arready_q <= arready_d;
            araddr_q  <= araddr_d;
            rdata_q   <= rdata_d;
            rresp_q   <= rresp_d;
            cnt_q     <= cnt_d;
        end
    end

    always_comb begin
        r_state_d = r_state_q;
        unique case (r_state_q)
            StRIdle:  if (ar_hs) r_state_d = StRIssue;
            StRIssue: r_state_d = (r_class == RespOkay) ? StRWait : StRResp;
            StRWait:  if (cnt_q == 2'd0) r_state_d = StRResp;
            StRResp:  if (s_axil_rready) r_state_d = StRIdle;
            default:  r_state_d = StRIdle;
        endcase
    end

    // cnt_q counts down the remaining cycles until i_reg_rdata is valid
    always_comb begin
        araddr_d = araddr_q;
        rdata_d  = rdata_q;
        rresp_d  = rresp_q;
        cnt_d    = cnt_q;
        if (ar_hs) begin
            araddr_d = s_axil_araddr;
        end
        if (r_state_q == StRIssue) begin
            rresp_d = r_class;
            cnt_d   = 2'(RD_LATENCY - 1);
            if (r_class != RespOkay) begin
                rdata_d = '0;
            end
        end
        if (r_state_q == StRWait) begin
            if (cnt_q == 2'd0) begin
                rdata_d = i_reg_rdata;
            end else begin
                cnt_d = cnt_q - 2'd1;
            end
        end
        arready_d = (r_state_d == StRIdle);
    end

    always_comb begin
        o_reg_ren      = (r_state_q == StRIssue) && (r_class == RespOkay);
        o_reg_raddr    = araddr_q[15:0];
        s_axil_arready = arready_q;
        s_axil_rvalid  = (r_state_q == StRResp);
        s_axil_rdata   = rdata_q;
        s_axil_rresp   = rresp_q;
    end

endmodule

// File: tb/tb_tlk2711_axil_reg_bridge.sv
// Scoreboard bench for tlk2711_axil_reg_bridge: drivers push expected strobes/responses,
// a negedge monitor pops and compares them, including exact cycle timing.
module tb_tlk2711_axil_reg_bridge;

    localparam int RDL = 3;

    logic        ps_clk = 1'b0;
    logic        ps_rst = 1'b1;
    logic [31:0] s_axil_awaddr = '0;
    logic        s_axil_awvalid = 1'b0;
    logic        s_axil_awready;
    logic [63:0] s_axil_wdata = '0;
    logic [7:0]  s_axil_wstrb = '0;
    logic        s_axil_wvalid = 1'b0;
    logic        s_axil_wready;
    logic [1:0]  s_axil_bresp;
    logic        s_axil_bvalid;
    logic        s_axil_bready = 1'b0;
    logic [31:0] s_axil_araddr = '0;
    logic        s_axil_arvalid = 1'b0;
    logic        s_axil_arready;
    logic [63:0] s_axil_rdata;
    logic [1:0]  s_axil_rresp;
    logic        s_axil_rvalid;
    logic        s_axil_rready = 1'b0;
    logic        o_reg_wen;
    logic [15:0] o_reg_waddr;
    logic [63:0] o_reg_wdata;
    logic        o_reg_ren;
    logic [15:0] o_reg_raddr;
    logic [63:0] i_reg_rdata;

    tlk2711_axil_reg_bridge #(
        .AXIL_ADDR_WIDTH(32),
        .RD_LATENCY     (RDL)
    ) dut (
        .ps_clk        (ps_clk),
        .ps_rst        (ps_rst),
        .s_axil_awaddr (s_axil_awaddr),
        .s_axil_awvalid(s_axil_awvalid),
        .s_axil_awready(s_axil_awready),
        .s_axil_wdata  (s_axil_wdata),
        .s_axil_wstrb  (s_axil_wstrb),
        .s_axil_wvalid (s_axil_wvalid),
        .s_axil_wready (s_axil_wready),
        .s_axil_bresp  (s_axil_bresp),
        .s_axil_bvalid (s_axil_bvalid),
        .s_axil_bready (s_axil_bready),
        .s_axil_araddr (s_axil_araddr),
        .s_axil_arvalid(s_axil_arvalid),
        .s_axil_arready(s_axil_arready),
        .s_axil_rdata  (s_axil_rdata),
        .s_axil_rresp  (s_axil_rresp),
        .s_axil_rvalid (s_axil_rvalid),
        .s_axil_rready (s_axil_rready),
        .o_reg_wen     (o_reg_wen),
        .o_reg_waddr   (o_reg_waddr),
        .o_reg_wdata   (o_reg_wdata),
        .o_reg_ren     (o_reg_ren),
        .o_reg_raddr   (o_reg_raddr),
        .i_reg_rdata   (i_reg_rdata)
    );

    always #5 ps_clk = ~ps_clk;

    int cyc = 0;
    always @(posedge ps_clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;
    bit hold_b = 1'b0;
    bit hold_r = 1'b0;

    typedef struct {logic [15:0] addr; logic [63:0] data; int cyc;} strobe_t;
    typedef struct {logic [1:0] resp; logic [63:0] data; int cyc;} resp_t;
    strobe_t wen_q[$];
    strobe_t ren_q[$];
    resp_t   b_q[$];
    resp_t   r_q[$];

    task automatic chk(input bit ok, input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s cyc=%0d actual=%h required=%h", name, cyc, act, exp);
        end
    endtask

    // Register-block model: the value a given offset reads back
    function automatic logic [63:0] rmodel(input logic [15:0] a);
        if (a == 16'h0018) return 64'h1122_3344_5566_7788;
        return {a ^ 16'hA5A5, ~a, a, 16'h3C3C};
    endfunction

    function automatic logic [1:0] resp_of(input logic [31:0] a, input logic [7:0] strb,
                                           input bit is_wr);
        if (a >= 32'h0001_0000) return 2'b11;
        if ((a % 8) != 0 || (is_wr && strb != 8'hFF)) return 2'b10;
        return 2'b00;
    endfunction

    function automatic logic [31:0] rand_addr();
        logic [31:0] a;
        int k;
        k = $urandom_range(0, 7);
        a = 32'($urandom_range(0, 65535)) & 32'h0000_FFF8;
        if (k == 0) a[31:16] = 16'($urandom_range(1, 65535));
        if (k == 1) a[2:0] = 3'($urandom_range(1, 7));
        return a;
    endfunction

    // Read data is valid exactly RDL cycles after the ren cycle, inverted garbage otherwise
    logic        pv [RDL];
    logic [15:0] pa [RDL];
    always @(posedge ps_clk) begin
        if (ps_rst) begin
            for (int i = 0; i < RDL; i++) begin
                pv[i] <= 1'b0;
                pa[i] <= '0;
            end
        end else begin
            pv[0] <= o_reg_ren;
            pa[0] <= o_reg_raddr;
            for (int i = 1; i < RDL; i++) begin
                pv[i] <= pv[i-1];
                pa[i] <= pa[i-1];
            end
        end
    end
    always_comb i_reg_rdata = pv[RDL-1] ? rmodel(pa[RDL-1]) : ~rmodel(pa[RDL-1]);

    always @(posedge ps_clk) begin
        #1;
        s_axil_bready = !hold_b && ($urandom_range(0, 2) != 0);
        s_axil_rready = !hold_r && ($urandom_range(0, 2) != 0);
    end

    // Monitor
    bit b_seen = 1'b0;
    bit r_seen = 1'b0;
    always @(negedge ps_clk) begin
        if (ps_rst) begin
            b_seen = 1'b0;
            r_seen = 1'b0;
        end else begin
            if (o_reg_wen) begin
                if (wen_q.size() == 0) begin
                    chk(1'b0, "wen_unexpected", {48'h0, o_reg_waddr}, 64'h0);
                end else begin
                    strobe_t e;
                    e = wen_q.pop_front();
                    chk(o_reg_waddr == e.addr, "wen_addr", 64'(o_reg_waddr), 64'(e.addr));
                    chk(o_reg_wdata == e.data, "wen_data", o_reg_wdata, e.data);
                    chk(cyc == e.cyc, "wen_cycle", 64'(cyc), 64'(e.cyc));
                end
            end
            if (s_axil_bvalid) begin
                if (b_q.size() == 0) begin
                    chk(1'b0, "bvalid_unexpected", 64'(s_axil_bresp), 64'h0);
                end else begin
                    chk(s_axil_bresp == b_q[0].resp, "bresp", 64'(s_axil_bresp),
                        64'(b_q[0].resp));
                    if (!b_seen) chk(cyc == b_q[0].cyc, "bvalid_cycle", 64'(cyc), 64'(b_q[0].cyc));
                    b_seen = 1'b1;
                    if (s_axil_bready) begin
                        void'(b_q.pop_front());
                        b_seen = 1'b0;
                    end
                end
            end
            if (o_reg_ren) begin
                if (ren_q.size() == 0) begin
                    chk(1'b0, "ren_unexpected", {48'h0, o_reg_raddr}, 64'h0);
                end else begin
                    strobe_t e;
                    e = ren_q.pop_front();
                    chk(o_reg_raddr == e.addr, "ren_addr", 64'(o_reg_raddr), 64'(e.addr));
                    chk(cyc == e.cyc, "ren_cycle", 64'(cyc), 64'(e.cyc));
                end
            end
            if (s_axil_rvalid) begin
                if (r_q.size() == 0) begin
                    chk(1'b0, "rvalid_unexpected", s_axil_rdata, 64'h0);
                end else begin
                    chk(s_axil_rresp == r_q[0].resp, "rresp", 64'(s_axil_rresp),
                        64'(r_q[0].resp));
                    chk(s_axil_rdata == r_q[0].data, "rdata", s_axil_rdata, r_q[0].data);
                    if (!r_seen) chk(cyc == r_q[0].cyc, "rvalid_cycle", 64'(cyc), 64'(r_q[0].cyc));
                    r_seen = 1'b1;
                    if (s_axil_rready) begin
                        void'(r_q.pop_front());
                        r_seen = 1'b0;
                    end
                end
            end
        end
    end

    // Drivers: called just after a rising edge
    task automatic write_txn(input logic [31:0] addr, input logic [63:0] data,
                             input logic [7:0] strb, input int aw_dly, input int w_dly,
                             input bit wait_b);
        int aw_n, w_n, n, t;
        logic [1:0] resp;
        aw_n = 0;
        w_n  = 0;
        fork
            begin
                int ta;
                repeat (aw_dly) begin @(posedge ps_clk); #1; end
                s_axil_awaddr  = addr;
                s_axil_awvalid = 1'b1;
                ta = 0;
                do begin @(negedge ps_clk); ta++; end while (!s_axil_awready && ta < 100);
                chk(s_axil_awready, "aw_handshake", 64'(s_axil_awready), 64'h1);
                aw_n = cyc;
                @(posedge ps_clk); #1;
                s_axil_awvalid = 1'b0;
            end
            begin
                int tw;
                repeat (w_dly) begin @(posedge ps_clk); #1; end
                s_axil_wdata  = data;
                s_axil_wstrb  = strb;
                s_axil_wvalid = 1'b1;
                tw = 0;
                do begin @(negedge ps_clk); tw++; end while (!s_axil_wready && tw < 100);
                chk(s_axil_wready, "w_handshake", 64'(s_axil_wready), 64'h1);
                w_n = cyc;
                @(posedge ps_clk); #1;
                s_axil_wvalid = 1'b0;
            end
        join
        n = (aw_n > w_n) ? aw_n : w_n;
        resp = resp_of(addr, strb, 1'b1);
        if (resp == 2'b00) wen_q.push_back('{addr: addr[15:0], data: data, cyc: n + 1});
        b_q.push_back('{resp: resp, data: 64'h0, cyc: n + 2});
        if (wait_b) begin
            t = 0;
            do begin @(negedge ps_clk); t++; end
            while (!(s_axil_bvalid && s_axil_bready) && t < 100);
            chk(s_axil_bvalid && s_axil_bready, "b_complete", 64'(s_axil_bvalid), 64'h1);
            @(posedge ps_clk); #1;
        end
    endtask

    task automatic read_txn(input logic [31:0] addr, input int ar_dly, input bit wait_r);
        int t;
        logic [1:0] resp;
        repeat (ar_dly) begin @(posedge ps_clk); #1; end
        s_axil_araddr  = addr;
        s_axil_arvalid = 1'b1;
        t = 0;
        do begin @(negedge ps_clk); t++; end while (!s_axil_arready && t < 100);
        chk(s_axil_arready, "ar_handshake", 64'(s_axil_arready), 64'h1);
        resp = resp_of(addr, 8'hFF, 1'b0);
        if (resp == 2'b00) begin
            ren_q.push_back('{addr: addr[15:0], data: 64'h0, cyc: cyc + 1});
            r_q.push_back('{resp: resp, data: rmodel(addr[15:0]), cyc: cyc + 2 + RDL});
        end else begin
            r_q.push_back('{resp: resp, data: 64'h0, cyc: cyc + 2});
        end
        @(posedge ps_clk); #1;
        s_axil_arvalid = 1'b0;
        if (wait_r) begin
            t = 0;
            do begin @(negedge ps_clk); t++; end
            while (!(s_axil_rvalid && s_axil_rready) && t < 100);
            chk(s_axil_rvalid && s_axil_rready, "r_complete", 64'(s_axil_rvalid), 64'h1);
            @(posedge ps_clk); #1;
        end
    endtask

    task automatic check_idle_reset_outputs(input string tag);
        chk(!s_axil_bvalid && !s_axil_rvalid && s_axil_bresp == 2'b00 && s_axil_rresp == 2'b00,
            {tag, "_resp"}, {s_axil_bvalid, s_axil_rvalid, s_axil_bresp, s_axil_rresp}, 64'h0);
        chk(!o_reg_wen && !o_reg_ren && o_reg_waddr == 16'h0 && o_reg_raddr == 16'h0 &&
            o_reg_wdata == 64'h0, {tag, "_regport"}, {o_reg_wen, o_reg_ren, o_reg_waddr}, 64'h0);
        chk(s_axil_rdata == 64'h0, {tag, "_rdata"}, s_axil_rdata, 64'h0);
    endtask

    initial begin
        int t;
        repeat (2) @(posedge ps_clk);
        @(negedge ps_clk);
        chk({s_axil_awready, s_axil_wready, s_axil_arready} == 3'b000, "rst_readies",
            64'({s_axil_awready, s_axil_wready, s_axil_arready}), 64'h0);
        check_idle_reset_outputs("rst");
        @(posedge ps_clk); #1;
        ps_rst = 1'b0;
        @(negedge ps_clk);
        chk({s_axil_awready, s_axil_wready, s_axil_arready} == 3'b000, "release_readies_low",
            64'({s_axil_awready, s_axil_wready, s_axil_arready}), 64'h0);
        @(negedge ps_clk);
        chk({s_axil_awready, s_axil_wready, s_axil_arready} == 3'b111, "idle_readies_high",
            64'({s_axil_awready, s_axil_wready, s_axil_arready}), 64'h7);
        @(posedge ps_clk); #1;

        write_txn(32'h0000_0010, 64'hDEAD_BEEF_0123_4567, 8'hFF, 0, 0, 1'b1);

        // W leads AW by two cycles; B held for five cycles
        fork
            write_txn(32'h0000_0008, 64'h0BAD_F00D_CAFE_0001, 8'hFF, 2, 0, 1'b1);
            begin
                hold_b = 1'b1;
                t = 0;
                do begin @(negedge ps_clk); t++; end while (!s_axil_bvalid && t < 100);
                repeat (5) @(negedge ps_clk);
                chk(s_axil_bvalid, "b_held_5", 64'(s_axil_bvalid), 64'h1);
                hold_b = 1'b0;
            end
        join

        read_txn(32'h0000_0018, 0, 1'b1);

        write_txn(32'h0001_0000, 64'h1, 8'hFF, 0, 0, 1'b1);
        write_txn(32'h0000_0004, 64'h2, 8'hFF, 0, 1, 1'b1);
        write_txn(32'h0000_0020, 64'h3, 8'h0F, 1, 0, 1'b1);
        read_txn(32'h0002_0040, 0, 1'b1);
        read_txn(32'h0000_001C, 0, 1'b1);

        fork
            write_txn(32'h0000_0030, 64'h5555_AAAA_1234_5678, 8'hFF, 0, 0, 1'b1);
            read_txn(32'h0000_0038, 0, 1'b1);
        join

        for (int i = 0; i < 60; i++) begin
            logic [31:0] wa, ra;
            logic [7:0]  st;
            int          op;
            op = $urandom_range(0, 2);
            wa = rand_addr();
            ra = rand_addr();
            st = ($urandom_range(0, 7) == 0) ? 8'($urandom) : 8'hFF;
            if (op == 0) begin
                write_txn(wa, {$urandom, $urandom}, st, $urandom_range(0, 2),
                          $urandom_range(0, 2), 1'b1);
            end else if (op == 1) begin
                read_txn(ra, $urandom_range(0, 2), 1'b1);
            end else begin
                fork
                    write_txn(wa, {$urandom, $urandom}, st, $urandom_range(0, 2),
                              $urandom_range(0, 2), 1'b1);
                    read_txn(ra, $urandom_range(0, 2), 1'b1);
                join
            end
        end

        // Reset while the write sits in its response phase and the read waits for data
        hold_b = 1'b1;
        hold_r = 1'b1;
        write_txn(32'h0000_0040, 64'h7777_8888_9999_AAAA, 8'hFF, 0, 0, 1'b0);
        repeat (2) begin @(posedge ps_clk); #1; end
        chk(s_axil_bvalid, "pre_rst_bvalid", 64'(s_axil_bvalid), 64'h1);
        read_txn(32'h0000_0048, 0, 1'b0);
        @(posedge ps_clk); #1;
        wen_q.delete();
        ren_q.delete();
        b_q.delete();
        r_q.delete();
        ps_rst = 1'b1;
        #1;
        chk(!s_axil_bvalid && !s_axil_rvalid, "rst_valids_immediate",
            64'({s_axil_bvalid, s_axil_rvalid}), 64'h0);
        repeat (2) begin @(posedge ps_clk); #1; end
        ps_rst = 1'b0;
        hold_b = 1'b0;
        hold_r = 1'b0;
        @(negedge ps_clk);
        chk({s_axil_awready, s_axil_arready} == 2'b00, "rst2_readies_low",
            64'({s_axil_awready, s_axil_arready}), 64'h0);
        check_idle_reset_outputs("rst2");
        @(negedge ps_clk);
        chk({s_axil_awready, s_axil_arready} == 2'b11, "rst2_readies_high",
            64'({s_axil_awready, s_axil_arready}), 64'h3);
        @(posedge ps_clk); #1;

        fork
            write_txn(32'h0000_0050, 64'h0123_4567_89AB_CDEF, 8'hFF, 0, 0, 1'b1);
            read_txn(32'h0000_0058, 1, 1'b1);
        join

        repeat (RDL + 4) @(posedge ps_clk);
        #1;
        chk(wen_q.size() == 0 && ren_q.size() == 0 && b_q.size() == 0 && r_q.size() == 0,
            "queues_drained", 64'(wen_q.size() + ren_q.size() + b_q.size() + r_q.size()), 64'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
